tiny_project_mux: RTL
=====================

TINY_PROJECT_MUX -- requirements
Module: tiny_project_mux

Interface
REQ-001 Parameter N_PROJ, default 4, number of hosted tiny projects (legal 2..16).
REQ-002 Parameter IO_W, default 38, width of the user IO bus.
REQ-003 Parameter BASE_ADR, default 32'h3000_0000, Wishbone register window base (256-byte window).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 wb_clk_i  in  1  sole clock.
REQ-006 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
REQ-008 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-009 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-010 io_in  in  IO_W  pad inputs; io_out, io_oeb  out  IO_W each  pad outputs/enables (oeb=1 means input).
REQ-011 proj_io_in  out  IO_W  io_in broadcast to all projects.
REQ-012 proj_io_out, proj_io_oeb  in  N_PROJ*IO_W each  per-project outputs, project k at bits [k*IO_W +: IO_W].
REQ-013 proj_rst_n  out  N_PROJ  per-project active-low reset.
REQ-014 user_irq  out  3  interrupts; only bit 0 is driven, bits 2:1 tied 0.

Function
REQ-015 Registers, offsets within the window: 0x00 CTRL {[8] en, [3:0] sel}, R/W; 0x04 STATUS {[8] err, [7:4] active, [1] running, [0] busy}, RO except err; 0x08 SETTLE [7:0], R/W; 0x0C CYCLES, RO.
REQ-016 Decode: wbs_adr_i[31:8]==BASE_ADR[31:8]; a cycle outside the window SHALL never be acked.
REQ-017 wbs_ack_o SHALL assert the cycle after cyc&stb is seen with no ack pending, and SHALL stay high exactly one cycle.
REQ-018 Writes SHALL honour wbs_sel_i per byte; reads of unmapped in-window offsets SHALL return 0 and ack.
REQ-019 Writing 1 to STATUS[8] SHALL clear err; reads of STATUS SHALL not change it.
REQ-020 FSM states: OFF, DRAIN, RELEASE, RUN.
REQ-021 OFF: all proj_rst_n=0, io_oeb all 1, io_out all 0; a CTRL write with en=1 and legal sel SHALL go to DRAIN.
REQ-022 DRAIN: outputs as in OFF; a down-counter loaded with SETTLE SHALL decrement once per cycle; at 0 the FSM SHALL go to RELEASE (SETTLE=0 means one DRAIN cycle).
REQ-023 RELEASE: proj_rst_n[active]=1, outputs still gated; next cycle the FSM SHALL enter RUN.
REQ-024 RUN: io_out/io_oeb SHALL equal the active project's slice combinationally; user_irq[0] SHALL pulse high one cycle on RUN entry.
REQ-025 CTRL write in RUN with a new legal sel SHALL go to DRAIN; with en=0 SHALL go to OFF.
REQ-026 busy=1 in DRAIN and RELEASE; a CTRL write while busy SHALL be ignored and SHALL set err.
REQ-027 A CTRL write with sel>=N_PROJ SHALL be ignored, SHALL set err, and SHALL leave the FSM state unchanged.
REQ-028 STATUS.active SHALL update only when the FSM enters DRAIN.

Reset
REQ-029 On wb_rst_ni low: FSM=OFF, CTRL=0, SETTLE=8'h10, err=0, CYCLES=0, wbs_ack_o=0, wbs_dat_o=0, user_irq=0, proj_rst_n=0, io_oeb all 1, io_out 0.
REQ-030 Reset asserted mid-DRAIN or mid-bus-cycle SHALL abort immediately with no ack issued.

Configuration
REQ-031 Macro TINY_MUX_CYCLE_CNT_EN defined: CYCLES SHALL be a 32-bit counter, incremented each RUN cycle, wrapping at 2^32-1 to 0, cleared on DRAIN entry.
REQ-032 Macro undefined: CYCLES SHALL read 0 and no counter flops SHALL exist.

Verification
REQ-033 Reset -> io_oeb all 1, proj_rst_n=0, STATUS reads 0x000.
REQ-034 Write CTRL=0x102, SETTLE=0x10 -> busy 18 cycles total (17 DRAIN + 1 RELEASE), then proj_rst_n=4'b0100, irq[0] one-cycle pulse, io_out equals proj 2 slice.
REQ-035 Write CTRL=0x105 with N_PROJ=4 -> err=1, FSM unchanged; write STATUS=0x100 -> err=0.
REQ-036 CTRL write while busy -> ignored, err=1; read of 0x40 -> 0 with ack; access to 0x3000_0100 -> no ack.
REQ-037 Reset asserted during DRAIN -> outputs at reset values in the same cycle; with the macro, CYCLES reads 0 after RUN re-entry.
REQ-038 Macro defined, 100 RUN cycles -> CYCLES=100; macro undefined -> CYCLES=0.

Source files
------------

// File: rtl/tiny_project_mux_if.sv
// Wishbone classic slave bus carrying the register window of tiny_project_mux.
// Valid/ready: a request is cyc&stb held by the master until ack; ack is a one-cycle response.
interface tiny_project_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/tiny_project_mux.sv
// Pad multiplexer selecting one of N_PROJ tiny projects, with a drain/reset-release sequence.
// Optional RUN-cycle counter enabled by defining TINY_MUX_CYCLE_CNT_EN.
module tiny_project_mux #(
    parameter int          N_PROJ   = 4,
    parameter int          IO_W     = 38,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    tiny_project_mux_if.slave      wbs,
    input  logic [IO_W-1:0]        io_in,
    output logic [IO_W-1:0]        io_out,
    output logic [IO_W-1:0]        io_oeb,
    output logic [IO_W-1:0]        proj_io_in,
    input  logic [N_PROJ*IO_W-1:0] proj_io_out,
    input  logic [N_PROJ*IO_W-1:0] proj_io_oeb,
    output logic [N_PROJ-1:0]      proj_rst_n,
    output logic [2:0]             user_irq
);

    localparam logic [4:0] NPROJ5 = 5'(N_PROJ);

    typedef enum logic [1:0] {S_OFF, S_DRAIN, S_RELEASE, S_RUN} state_t;

    state_t            r_state;
    logic              r_en;
    logic [3:0]        r_sel;
    logic [3:0]        r_active;
    logic [7:0]        r_settle;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_irq;
    logic [N_PROJ-1:0] r_proj_rst_n;

    logic              w_hit;
    logic              w_req;
    logic              w_wr;
    logic              w_rd;
    logic [7:0]        w_off;
    logic              w_busy;
    logic              w_running;
    logic              w_new_en;
    logic [3:0]        w_new_sel;
    logic              w_sel_ok;
    logic              w_ctrl_wr;
    logic              w_ctrl_ok;
    logic              w_enter_drain;
    logic              w_enter_off;
    logic [31:0]       w_status;
    logic [31:0]       w_cycles;
    logic [31:0]       w_rdata;
    logic [N_PROJ-1:0] w_active_oh;
    logic [IO_W-1:0]   w_slice_out;
    logic [IO_W-1:0]   w_slice_oeb;
    logic              w_unused;

    assign w_hit     = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & w_hit & ~r_ack;
    assign w_wr      = w_req & wbs.wbs_we_i;
    assign w_rd      = w_req & ~wbs.wbs_we_i;
    assign w_off     = wbs.wbs_adr_i[7:0];
    assign w_busy    = (r_state == S_DRAIN) || (r_state == S_RELEASE);
    assign w_running = (r_state == S_RUN);

    // CTRL fields not covered by an enabled byte lane keep their stored value.
    assign w_new_en  = wbs.wbs_sel_i[1] ? wbs.wbs_dat_i[8]   : r_en;
    assign w_new_sel = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[3:0] : r_sel;
    assign w_sel_ok  = ({1'b0, w_new_sel} < NPROJ5);
    assign w_ctrl_wr = w_wr && (w_off == 8'h00);
    assign w_ctrl_ok = w_ctrl_wr && !w_busy && w_sel_ok;

    assign w_enter_off   = w_ctrl_ok && !w_new_en;
    assign w_enter_drain = w_ctrl_ok && w_new_en &&
                           ((r_state == S_OFF) || (w_new_sel != r_active));

    assign w_status = {23'd0, r_err, r_active, 2'b00, w_running, w_busy};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            8'h00:   w_rdata = {23'd0, r_en, 4'd0, r_sel};
            8'h04:   w_rdata = w_status;
            8'h08:   w_rdata = {24'd0, r_settle};
            8'h0C:   w_rdata = w_cycles;
            default: w_rdata = '0;
        endcase
    end

    assign w_active_oh = {{(N_PROJ-1){1'b0}}, 1'b1} << r_active;
    assign w_slice_out = proj_io_out[int'(r_active) * IO_W +: IO_W];
    assign w_slice_oeb = proj_io_oeb[int'(r_active) * IO_W +: IO_W];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= S_OFF;
            r_en         <= 1'b0;
            r_sel        <= 4'd0;
            r_active     <= 4'd0;
            r_settle     <= 8'h10;
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
            r_ack        <= 1'b0;
            r_dat        <= 32'd0;
            r_irq        <= 1'b0;
            r_proj_rst_n <= '0;
        end else begin
            r_ack <= w_req;
            r_irq <= 1'b0;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
            if (w_wr && (w_off == 8'h08) && wbs.wbs_sel_i[0]) begin
                r_settle <= wbs.wbs_dat_i[7:0];
            end
            if (w_wr && (w_off == 8'h04) && wbs.wbs_sel_i[1] && wbs.wbs_dat_i[8]) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_DRAIN: begin
                    if (r_cnt == 8'd0) begin
                        r_state      <= S_RELEASE;
                        r_proj_rst_n <= w_active_oh;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_RUN;
                    r_irq   <= 1'b1;
                end
                default: ;
            endcase

            // CTRL writes are only acted on outside DRAIN/RELEASE and with a hosted project.
            if (w_ctrl_wr && (w_busy || !w_sel_ok)) begin
                r_err <= 1'b1;
            end
            if (w_ctrl_ok) begin
                r_en  <= w_new_en;
                r_sel <= w_new_sel;
            end
            if (w_enter_off) begin
                r_state      <= S_OFF;
                r_proj_rst_n <= '0;
            end
            if (w_enter_drain) begin
                r_state      <= S_DRAIN;
                r_active     <= w_new_sel;
                r_cnt        <= r_settle;
                r_proj_rst_n <= '0;
            end
        end
    end

`ifdef TINY_MUX_CYCLE_CNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cycles <= 32'd0;
        end else if (w_enter_drain) begin
            r_cycles <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 32'd0;
`endif

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    // Pads only see a project once it is fully out of reset and RUN has been entered.
    assign io_out     = w_running ? w_slice_out : {IO_W{1'b0}};
    assign io_oeb     = w_running ? w_slice_oeb : {IO_W{1'b1}};
    assign proj_io_in = io_in;
    assign proj_rst_n = r_proj_rst_n;
    assign user_irq   = {2'b00, r_irq};

    assign w_unused = ^{wbs.wbs_dat_i[31:9], wbs.wbs_sel_i[3:2]};

endmodule
